// File: rtl/lsu_bus_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and the memory slave.
// Latency: none, this is wiring only.
// Backpressure: the slave holds off the master by withholding bus_ack.
interface lsu_bus_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: one bus transaction per MEM-stage load/store, lane steering and load extension.
// Latency: request at T -> bus_req at T+1; ack at T+1+w -> done at T+2+w (misaligned with MISALIGN_EXC_EN: done at T+1).
// Backpressure: stall = mem_req & ~done holds the pipeline until the bus acknowledges.
// Optional feature macro: MISALIGN_EXC_EN (misaligned half/word raises adel/ades, no bus access).
module lsu_bus_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_req,
  input  logic [2:0]    lshb,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          adel,
  output logic          ades,
  lsu_bus_ctrl_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [2:0]    lshb_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic          is_store;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic [3:0]    be_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [DW-1:0] ext;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  // Decode the incoming request: direction, size class, lane mask and replicated store data.
  always_comb begin
    is_store  = lshb[2] & (lshb != 3'b100);
    is_byte   = (lshb == 3'b000) | (lshb == 3'b001) | (lshb == 3'b101);
    is_half   = (lshb == 3'b010) | (lshb == 3'b011) | (lshb == 3'b110);
    is_word   = (lshb == 3'b100) | (lshb == 3'b111);
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    if (is_byte) begin
      be_nxt    = 4'b0001 << addr[1:0];
      wdata_nxt = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{wdata[15:0]}};
    end
  end

  // Pick the addressed lane out of the returned word and sign/zero-extend it.
  always_comb begin
    lane_b = bus.bus_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (lshb_q)
      3'b000:  ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext = {24'd0, lane_b};
      3'b010:  ext = {{16{lane_h[15]}}, lane_h};
      3'b011:  ext = {16'd0, lane_h};
      default: ext = bus.bus_rdata;
    endcase
  end

`ifdef MISALIGN_EXC_EN
  logic adel_q;
  logic ades_q;
  logic misaligned;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  always_comb begin
    misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  end
`endif

  // Request FSM: IDLE latches the access, BUS waits for ack, DONE pulses once and never re-issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lshb_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_EXC_EN
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            lshb_q  <= lshb;
            off_q   <= addr[1:0];
            we_q    <= is_store;
            be_q    <= be_nxt;
            addr_q  <= {addr[AW-1:2], 2'b00};
            wdata_q <= wdata_nxt;
            rdata_q <= '0;
            state   <= BUS;
`ifdef MISALIGN_EXC_EN
            adel_q  <= misaligned & ~is_store;
            ades_q  <= misaligned & is_store;
            if (misaligned) state <= DONE;
`endif
          end
        end
        BUS: begin
          if (bus.bus_ack) begin
            rdata_q <= we_q ? '0 : ext;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign done          = (state == DONE);
  assign stall         = mem_req & ~done;
  assign rdata         = rdata_q;
  assign bus.bus_req   = (state == BUS);
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

`ifdef MISALIGN_EXC_EN
  assign adel = adel_q;
  assign ades = ades_q;
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

endmodule
